// File: rtl/prio_encoder8_if.sv
// Request/offer bus of the 8-to-3 priority encoder. The consumer side uses the master modport
// and the encoder uses the slave modport.
interface prio_encoder8_if;
  logic       ein;
  logic [7:0] reqn;
  logic       ack;
  logic [2:0] code;
  logic       valid;
  logic       gsn;
  logic       eon;
  logic [7:0] pending;
  logic       overrun;

  modport master (
    output ein, reqn, ack,
    input  code, valid, gsn, eon, pending, overrun
  );

  modport slave (
    input  ein, reqn, ack,
    output code, valid, gsn, eon, pending, overrun
  );
endinterface

// File: rtl/prio_encoder8.sv
// Registered 8-to-3 priority encoder. It latches active-low request lines into a pending
// vector and offers the highest pending index over a valid/ack handshake.
module prio_encoder8 #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 1
) (
  input logic           clk,
  input logic           rst_n,
  prio_encoder8_if.slave bus
);

  if (SYNC_STAGES < 1 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES must be in 1..3");
  end

  typedef enum logic [0:0] {StIdle, StOffer} state_e;

  state_e     state_q;
  logic [7:0] sync_q [SYNC_STAGES];
  logic [7:0] hist_q;
  logic [7:0] pending_q, pending_d;
  logic [2:0] code_q;
  logic       valid_q;
  logic       overrun_q, overrun_d;

  logic [7:0] s;
  logic [7:0] set_vec;
  logic [7:0] clr_vec;
  logic [2:0] top_idx;

  // Reset to all-ones so a line held low across reset shows up as one fresh edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 8'hFF;
      hist_q <= 8'hFF;
    end else begin
      sync_q[0] <= bus.reqn;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      hist_q <= s;
    end
  end

  always_comb begin
    s       = sync_q[SYNC_STAGES-1];
    set_vec = (EDGE_MODE != 0) ? (hist_q & ~s) : ~s;
    clr_vec = '0;
    if (state_q == StOffer && bus.ack) clr_vec[code_q] = 1'b1;
    // Set is ORed in after the clear so a same-cycle re-request survives the ack.
    pending_d = (pending_q & ~clr_vec) | set_vec;
    overrun_d = (EDGE_MODE != 0) && (|(set_vec & pending_q & ~clr_vec));
    top_idx   = '0;
    for (int i = 0; i < 8; i++) begin
      if (pending_q[i]) top_idx = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      unique case (state_q)
        StIdle: begin
          if (!bus.ein && pending_q != '0) begin
            code_q  <= top_idx;
            valid_q <= 1'b1;
            state_q <= StOffer;
          end
        end
        StOffer: begin
          if (bus.ack) begin
            valid_q <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.code    = code_q;
  assign bus.valid   = valid_q;
  assign bus.gsn     = ~valid_q;
  assign bus.eon     = ~(~bus.ein & ~valid_q & ~(|pending_q));
  assign bus.pending = pending_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_prio_encoder8.sv
// Bench for prio_encoder8: table-driven directed vectors, a reset-release sequence and a
// randomized run checked against a behavioural reference model.
module tb_prio_encoder8;
  localparam int unsigned SYNC = 2;
  localparam int unsigned EDGE = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prio_encoder8_if bus ();

  prio_encoder8 #(
    .SYNC_STAGES(SYNC),
    .EDGE_MODE  (EDGE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packed view of the outputs: {valid, code-when-valid, pending, gsn, eon, overrun}.
  function automatic logic [15:0] dut_view();
    return {bus.valid, (bus.valid ? bus.code : 3'd0), bus.pending, bus.gsn, bus.eon,
            bus.overrun};
  endfunction

  function automatic logic [15:0] exp_view(input logic v, input logic [2:0] c,
                                            input logic [7:0] p, input logic e,
                                            input logic ov);
    logic eon_low;
    eon_low = !e && !v && (p == 8'h00);
    return {v, (v ? c : 3'd0), p, !v, !eon_low, ov};
  endfunction

  typedef struct {
    logic [7:0] reqn;
    logic       ein;
    logic       ack;
    logic       valid;
    logic [2:0] code;
    logic [7:0] pend;
    logic       ov;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] r, input logic e, input logic a, input logic v,
                     input logic [2:0] c, input logic [7:0] p, input logic ov);
    vec_t x;
    x.reqn = r; x.ein = e; x.ack = a; x.valid = v; x.code = c; x.pend = p; x.ov = ov;
    tbl.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) add(8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  // Reference model: spec-level view with a delay line of sampled request words.
  logic [7:0] m_line [0:SYNC];
  logic [7:0] m_pend;
  logic       m_valid;
  int         m_code;
  logic       m_ov;

  task automatic model_reset();
    for (int i = 0; i <= SYNC; i++) m_line[i] = 8'hFF;
    m_pend = 8'h00; m_valid = 1'b0; m_code = 0; m_ov = 1'b0;
  endtask

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_step(input logic [7:0] r, input logic e, input logic a);
    logic [7:0] s, h, setv, clr;
    s = m_line[SYNC-1];
    h = m_line[SYNC];
    setv = (EDGE != 0) ? (h & ~s) : ~s;
    clr = 8'h00;
    if (m_valid && a) clr = 8'h01 << m_code;
    m_ov = (EDGE != 0) && ((setv & m_pend & ~clr) != 8'h00);
    if (m_valid) begin
      if (a) m_valid = 1'b0;
    end else if (!e && m_pend != 8'h00) begin
      m_valid = 1'b1;
      m_code  = highest(m_pend);
    end
    m_pend = (m_pend & ~clr) | setv;
    for (int i = SYNC; i > 0; i--) m_line[i] = m_line[i-1];
    m_line[0] = r;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    int n;
    bus.ein = 1'b0; bus.reqn = 8'hFF; bus.ack = 1'b0;

    // Reset state, then 10 quiet cycles after release.
    #12;
    check("reset", 32'(dut_view()), 32'(exp_view(1'b0, 3'd0, 8'h00, 1'b0, 1'b0)));
    check("reset_code", 32'(bus.code), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check($sformatf("post_reset%0d", i), 32'(dut_view()),
            32'(exp_view(1'b0, 3'd0, 8'h00, 1'b0, 1'b0)));
    end

    // Single request on line 5.
    add(8'hDF, 0, 0, 0, 0, 8'h00, 0);
    add(8'hDF, 0, 0, 0, 0, 8'h00, 0);
    add(8'hDF, 0, 0, 0, 0, 8'h20, 0);
    add(8'hDF, 0, 0, 1, 5, 8'h20, 0);
    add(8'hFF, 0, 1, 0, 0, 8'h00, 0);
    idle(2);
    // Lines 6 and 2 together.
    add(8'hBB, 0, 0, 0, 0, 8'h00, 0);
    add(8'hBB, 0, 0, 0, 0, 8'h00, 0);
    add(8'hBB, 0, 0, 0, 0, 8'h44, 0);
    add(8'hBB, 0, 0, 1, 6, 8'h44, 0);
    add(8'hBB, 0, 1, 0, 0, 8'h04, 0);
    add(8'hBB, 0, 0, 1, 2, 8'h04, 0);
    add(8'hBB, 0, 1, 0, 0, 8'h00, 0);
    idle(3);
    // Line 3 offered, line 7 arrives without preempting.
    add(8'hF7, 0, 0, 0, 0, 8'h00, 0);
    add(8'hF7, 0, 0, 0, 0, 8'h00, 0);
    add(8'hF7, 0, 0, 0, 0, 8'h08, 0);
    add(8'hF7, 0, 0, 1, 3, 8'h08, 0);
    add(8'h77, 0, 0, 1, 3, 8'h08, 0);
    add(8'h77, 0, 0, 1, 3, 8'h08, 0);
    for (int i = 0; i < 4; i++) add(8'h77, 0, 0, 1, 3, 8'h88, 0);
    add(8'h77, 0, 1, 0, 0, 8'h80, 0);
    add(8'h77, 0, 0, 1, 7, 8'h80, 0);
    add(8'h77, 0, 1, 0, 0, 8'h00, 0);
    idle(3);
    // Line 1 falls, rises, falls again before ack.
    add(8'hFD, 0, 0, 0, 0, 8'h00, 0);
    add(8'hFD, 0, 0, 0, 0, 8'h00, 0);
    add(8'hFD, 0, 0, 0, 0, 8'h02, 0);
    add(8'hFD, 0, 0, 1, 1, 8'h02, 0);
    add(8'hFF, 0, 0, 1, 1, 8'h02, 0);
    add(8'hFD, 0, 0, 1, 1, 8'h02, 0);
    add(8'hFD, 0, 0, 1, 1, 8'h02, 0);
    add(8'hFD, 0, 0, 1, 1, 8'h02, 1);
    add(8'hFD, 0, 0, 1, 1, 8'h02, 0);
    add(8'hFD, 0, 1, 0, 0, 8'h00, 0);
    add(8'hFD, 0, 0, 0, 0, 8'h00, 0);
    add(8'hFD, 0, 0, 0, 0, 8'h00, 0);
    idle(3);
    // Enable blocks offers; ack while idle clears nothing.
    add(8'hEF, 1, 0, 0, 0, 8'h00, 0);
    add(8'hEF, 1, 0, 0, 0, 8'h00, 0);
    add(8'hEF, 1, 0, 0, 0, 8'h10, 0);
    add(8'hEF, 1, 1, 0, 0, 8'h10, 0);
    add(8'hEF, 1, 0, 0, 0, 8'h10, 0);
    add(8'hEF, 0, 0, 1, 4, 8'h10, 0);

    foreach (tbl[k]) begin
      @(negedge clk);
      bus.reqn = tbl[k].reqn; bus.ein = tbl[k].ein; bus.ack = tbl[k].ack;
      @(posedge clk); #1;
      check($sformatf("vec%0d", k), 32'(dut_view()),
            32'(exp_view(tbl[k].valid, tbl[k].code, tbl[k].pend, tbl[k].ein, tbl[k].ov)));
    end

    // Reset mid-offer drops everything at once; the held line re-offers after release.
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_offer", 32'(dut_view()), 32'(exp_view(1'b0, 3'd0, 8'h00, 1'b0, 1'b0)));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!bus.valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("reoffer_latency", 32'(n), 32'(SYNC + 2));
    check("reoffer_code", 32'(bus.code), 32'd4);
    @(negedge clk); bus.ack = 1'b1;
    @(posedge clk); #1;
    check("reoffer_ack", 32'(dut_view()), 32'(exp_view(1'b0, 3'd0, 8'h00, 1'b0, 1'b0)));
    @(negedge clk); bus.ack = 1'b0; bus.reqn = 8'hFF;

    // Randomized run against the reference model, starting from a fresh reset.
    rst_n = 1'b0;
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    r = 8'hFF;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      rst_n = 1'b1;
      if ($urandom_range(0, 3) == 0) r[$urandom_range(0, 7)] ^= 1'b1;
      bus.reqn = r;
      bus.ein  = ($urandom_range(0, 7) == 0);
      bus.ack  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 249) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end
      @(posedge clk);
      if (rst_n) model_step(bus.reqn, bus.ein, bus.ack);
      #1;
      check($sformatf("rand%0d", c), 32'(dut_view()),
            32'(exp_view(m_valid, 3'(m_code), m_pend, bus.ein, m_ov)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
